if_id_pipe_reg: RTL and testbench

Parametrised IF/ID pipeline register with built-in control-transfer freeze. It sits between instruction fetch and decode. It latches PC+4 and the fetched instruction, holds them while the cache is busy, and kills the stage on a flush. On detecting a jump or branch it asserts a freeze to fetch for a configurable number of cycles and inserts bubbles meanwhile. It replaces the fixed 3-cycle, reset-less IF register with a generalised, resettable version.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/cti_decode.sv | 31 +++
 rtl/if_id_pipe_reg.sv | 107 ++++++++++
 tb/tb_if_id_pipe_reg.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared IF/ID pipeline definitions: MIPS opcode/funct fields for control
// transfers, the default bubble instruction and the IF-stage state type.
package pipe_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] FN_JR     = 6'b001000;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;
  localparam int          CNT_W       = 4;

  typedef enum logic {
    RUN,
    FREEZE
  } if_state_t;

endpackage

// File: rtl/cti_decode.sv
// Combinational control-transfer detector (jr, branches, j/jal) on the low
// 32 bits of an instruction word; shared with the ID-stage hazard unit.
module cti_decode
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] inst_i,
  output logic              cti_o
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_ok;

  assign opcode    = inst_i[31:26];
  assign funct     = inst_i[5:0];
  // Only the opcode and funct fields matter; the rest is folded away.
  assign unused_ok = ^inst_i;

  always_comb begin
    cti_o = 1'b0;
    case (opcode)
      OP_RTYPE: cti_o = (funct == FN_JR);
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
      OP_REGIMM, OP_J, OP_JAL: cti_o = 1'b1;
      default: cti_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: latches PC+4 and the instruction, holds on stall,
// kills on flush, and freezes fetch for FREEZE_CYCLES after a control transfer.
module if_id_pipe_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W        = 32,
  parameter int                FREEZE_CYCLES = 3,
  parameter int                FREEZE_EN     = 1,
  parameter logic [DATA_W-1:0] NOP_INST      = DATA_W'(NOP_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] pc_plus_4_i,
  input  logic [DATA_W-1:0] inst_i,
  input  logic              valid_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] pc_plus_4_o,
  output logic [DATA_W-1:0] inst_o,
  output logic              valid_o,
  output logic              jmp_freeze_o,
  output logic              is_cti_o
);

  if (FREEZE_CYCLES < 1 || FREEZE_CYCLES > 15 || DATA_W < 32) begin : g_bad_cfg
    $error("if_id_pipe_reg: FREEZE_CYCLES must be 1..15 and DATA_W at least 32");
  end

  localparam logic             FREEZE_ON = (FREEZE_EN != 0);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(FREEZE_CYCLES);

  if_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              valid_q, valid_d;
  logic              cti_q, cti_d;
  logic              cti;

  cti_decode #(.DATA_W(DATA_W)) u_cti_decode (
    .inst_i (inst_i),
    .cti_o  (cti)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      pc_q    <= '0;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
      cti_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      cti_q   <= cti_d;
    end
  end

  // Flush beats stall, stall beats the normal RUN/FREEZE behaviour.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    cti_d   = cti_q;
    if (flush_i) begin
      state_d = RUN;
      cnt_d   = '0;
      inst_d  = NOP_INST;
      valid_d = 1'b0;
      cti_d   = 1'b0;
    end else if (!stall_i) begin
      case (state_q)
        RUN: begin
          pc_d    = pc_plus_4_i;
          inst_d  = valid_i ? inst_i : NOP_INST;
          valid_d = valid_i;
          cti_d   = valid_i & cti;
          if (valid_i && cti && FREEZE_ON) begin
            state_d = FREEZE;
            cnt_d   = CNT_LOAD;
          end
        end
        FREEZE: begin
          inst_d  = NOP_INST;
          valid_d = 1'b0;
          cti_d   = 1'b0;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == 1) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign pc_plus_4_o  = pc_q;
  assign inst_o       = inst_q;
  assign valid_o      = valid_q;
  assign is_cti_o     = cti_q;
  assign jmp_freeze_o = (state_q == FREEZE);

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed bench for if_id_pipe_reg: default, FREEZE_EN=0 and two 64-bit
// instances (FREEZE_CYCLES 1 and 15) checked against hand-computed values.
module tb_if_id_pipe_reg;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc, inst;
  logic [63:0] pc64, inst64;
  logic        valid, stall, flush;

  logic [31:0] pcA, instA, pcB, instB;
  logic        validA, frzA, ctiA, validB, frzB, ctiB;
  logic [63:0] pcC, instC, pcD, instD;
  logic        validC, frzC, ctiC, validD, frzD, ctiD;

  int vectors     = 0;
  int miscompares = 0;

  if_id_pipe_reg u_dut_a (
    .clk(clk), .rst_n(rst_n), .pc_plus_4_i(pc), .inst_i(inst), .valid_i(valid),
    .stall_i(stall), .flush_i(flush), .pc_plus_4_o(pcA), .inst_o(instA),
    .valid_o(validA), .jmp_freeze_o(frzA), .is_cti_o(ctiA)
  );

  if_id_pipe_reg #(.FREEZE_EN(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .pc_plus_4_i(pc), .inst_i(inst), .valid_i(valid),
    .stall_i(stall), .flush_i(flush), .pc_plus_4_o(pcB), .inst_o(instB),
    .valid_o(validB), .jmp_freeze_o(frzB), .is_cti_o(ctiB)
  );

  if_id_pipe_reg #(.DATA_W(64), .FREEZE_CYCLES(1), .NOP_INST(64'h0)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .pc_plus_4_i(pc64), .inst_i(inst64), .valid_i(valid),
    .stall_i(stall), .flush_i(flush), .pc_plus_4_o(pcC), .inst_o(instC),
    .valid_o(validC), .jmp_freeze_o(frzC), .is_cti_o(ctiC)
  );

  if_id_pipe_reg #(.DATA_W(64), .FREEZE_CYCLES(15), .NOP_INST(64'h0)) u_dut_d (
    .clk(clk), .rst_n(rst_n), .pc_plus_4_i(pc64), .inst_i(inst64), .valid_i(valid),
    .stall_i(stall), .flush_i(flush), .pc_plus_4_o(pcD), .inst_o(instD),
    .valid_o(validD), .jmp_freeze_o(frzD), .is_cti_o(ctiD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pc = '0; inst = '0; valid = 1'b0; stall = 1'b0; flush = 1'b0;
    pc64 = '0; inst64 = '0;
    #3;
    vectors++; if (pcA !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_pc got %h expected %h", pcA, 32'h0); end
    vectors++; if (instA !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_inst got %h expected %h", instA, 32'h0); end
    vectors++; if (validA !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got %b expected 0", validA); end
    vectors++; if (ctiA !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cti got %b expected 0", ctiA); end
    vectors++; if (frzA !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_frz got %b expected 0", frzA); end
    rst_n = 1'b1;
    step();
    pc = 32'h0000_0104; inst = 32'h1000_0004; valid = 1'b1;
    step();
    vectors++; if (frzA !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_prefrz got %b expected 1", frzA); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (frzA !== 1'b0) begin miscompares++; $display("[TB] FAIL async_frz got %b expected 0", frzA); end
    vectors++; if (pcA !== 32'h0) begin miscompares++; $display("[TB] FAIL async_pc got %h expected %h", pcA, 32'h0); end
    vectors++; if (instA !== 32'h0) begin miscompares++; $display("[TB] FAIL async_inst got %h expected %h", instA, 32'h0); end
    vectors++; if (validA !== 1'b0) begin miscompares++; $display("[TB] FAIL async_valid got %b expected 0", validA); end
    vectors++; if (ctiA !== 1'b0) begin miscompares++; $display("[TB] FAIL async_cti got %b expected 0", ctiA); end
    #1 rst_n = 1'b1;
    pc = 32'h0000_0008; inst = 32'h2008_0005; valid = 1'b1;
    step();
    vectors++; if (instA !== 32'h2008_0005) begin miscompares++; $display("[TB] FAIL postrst_inst got %h expected %h", instA, 32'h2008_0005); end
    vectors++; if (validA !== 1'b1) begin miscompares++; $display("[TB] FAIL postrst_valid got %b expected 1", validA); end
    vectors++; if (frzA !== 1'b0) begin miscompares++; $display("[TB] FAIL postrst_frz got %b expected 0", frzA); end
    vectors++; if (pcA !== 32'h0000_0008) begin miscompares++; $display("[TB] FAIL postrst_pc got %h expected %h", pcA, 32'h8); end
  endtask

  task automatic test_freeze_timing();
    pc = 32'h0000_0104; inst = 32'h1000_0004; valid = 1'b1;
    step();
    vectors++; if (frzA !== 1'b1) begin miscompares++; $display("[TB] FAIL ft_e_frz got %b expected 1", frzA); end
    vectors++; if (ctiA !== 1'b1) begin miscompares++; $display("[TB] FAIL ft_e_cti got %b expected 1", ctiA); end
    vectors++; if (instA !== 32'h1000_0004) begin miscompares++; $display("[TB] FAIL ft_e_inst got %h expected %h", instA, 32'h1000_0004); end
    pc = 32'h0000_0108; inst = 32'h2008_0005;
    for (int k = 1; k <= 3; k++) begin
      step();
      vectors++; if (frzA !== (k < 3)) begin miscompares++; $display("[TB] FAIL ft_frz%0d got %b expected %b", k, frzA, (k < 3)); end
      vectors++; if (validA !== 1'b0) begin miscompares++; $display("[TB] FAIL ft_valid%0d got %b expected 0", k, validA); end
      vectors++; if (instA !== 32'h0) begin miscompares++; $display("[TB] FAIL ft_inst%0d got %h expected %h", k, instA, 32'h0); end
      vectors++; if (ctiA !== 1'b0) begin miscompares++; $display("[TB] FAIL ft_cti%0d got %b expected 0", k, ctiA); end
      vectors++; if (pcA !== 32'h0000_0104) begin miscompares++; $display("[TB] FAIL ft_pc%0d got %h expected %h", k, pcA, 32'h104); end
    end
    step();
    vectors++; if (instA !== 32'h2008_0005) begin miscompares++; $display("[TB] FAIL ft_next_inst got %h expected %h", instA, 32'h2008_0005); end
    vectors++; if (validA !== 1'b1) begin miscompares++; $display("[TB] FAIL ft_next_valid got %b expected 1", validA); end
    vectors++; if (pcA !== 32'h0000_0108) begin miscompares++; $display("[TB] FAIL ft_next_pc got %h expected %h", pcA, 32'h108); end
    valid = 1'b0;
    step();
    vectors++; if (instA !== 32'h0) begin miscompares++; $display("[TB] FAIL ft_bubble_inst got %h expected %h", instA, 32'h0); end
  endtask

  task automatic test_stall_in_freeze();
    pc = 32'h0000_0300; inst = 32'h2008_0005; valid = 1'b1;
    step();
    stall = 1'b1; pc = 32'h0000_0304; inst = 32'h1000_0004;
    step();
    vectors++; if (instA !== 32'h2008_0005) begin miscompares++; $display("[TB] FAIL st_run_inst got %h expected %h", instA, 32'h2008_0005); end
    vectors++; if (pcA !== 32'h0000_0300) begin miscompares++; $display("[TB] FAIL st_run_pc got %h expected %h", pcA, 32'h300); end
    vectors++; if (frzA !== 1'b0) begin miscompares++; $display("[TB] FAIL st_run_frz got %b expected 0", frzA); end
    stall = 1'b0;
    step();
    vectors++; if (frzA !== 1'b1) begin miscompares++; $display("[TB] FAIL st_e_frz got %b expected 1", frzA); end
    inst = 32'h2008_0005; pc = 32'h0000_0308;
    for (int k = 0; k < 5; k++) begin
      stall = (k == 1 || k == 2);
      step();
      vectors++; if (frzA !== (k < 4)) begin miscompares++; $display("[TB] FAIL st_frz%0d got %b expected %b", k, frzA, (k < 4)); end
      vectors++; if (validA !== 1'b0) begin miscompares++; $display("[TB] FAIL st_valid%0d got %b expected 0", k, validA); end
      vectors++; if (pcA !== 32'h0000_0304) begin miscompares++; $display("[TB] FAIL st_pc%0d got %h expected %h", k, pcA, 32'h304); end
    end
    stall = 1'b0;
    step();
    vectors++; if (validA !== 1'b1) begin miscompares++; $display("[TB] FAIL st_next_valid got %b expected 1", validA); end
    vectors++; if (pcA !== 32'h0000_0308) begin miscompares++; $display("[TB] FAIL st_next_pc got %h expected %h", pcA, 32'h308); end
  endtask

  task automatic test_flush_in_freeze();
    pc = 32'h0000_0200; inst = 32'h0800_0010; valid = 1'b1;
    step();
    vectors++; if (ctiA !== 1'b1) begin miscompares++; $display("[TB] FAIL fl_e_cti got %b expected 1", ctiA); end
    pc = 32'h0000_0204; inst = 32'h2008_0005;
    step();
    flush = 1'b1; stall = 1'b1;
    step();
    vectors++; if (frzA !== 1'b0) begin miscompares++; $display("[TB] FAIL fl_frz got %b expected 0", frzA); end
    vectors++; if (validA !== 1'b0) begin miscompares++; $display("[TB] FAIL fl_valid got %b expected 0", validA); end
    vectors++; if (pcA !== 32'h0000_0200) begin miscompares++; $display("[TB] FAIL fl_pc got %h expected %h", pcA, 32'h200); end
    flush = 1'b0; stall = 1'b0;
    step();
    vectors++; if (instA !== 32'h2008_0005) begin miscompares++; $display("[TB] FAIL fl_run_inst got %h expected %h", instA, 32'h2008_0005); end
    vectors++; if (pcA !== 32'h0000_0204) begin miscompares++; $display("[TB] FAIL fl_run_pc got %h expected %h", pcA, 32'h204); end
    flush = 1'b1; inst = 32'h1000_0004; pc = 32'h0000_0208;
    step();
    vectors++; if (frzA !== 1'b0) begin miscompares++; $display("[TB] FAIL fl_cti_frz got %b expected 0", frzA); end
    vectors++; if (ctiA !== 1'b0) begin miscompares++; $display("[TB] FAIL fl_cti_cti got %b expected 0", ctiA); end
    vectors++; if (instA !== 32'h0) begin miscompares++; $display("[TB] FAIL fl_cti_inst got %h expected %h", instA, 32'h0); end
    vectors++; if (pcA !== 32'h0000_0204) begin miscompares++; $display("[TB] FAIL fl_cti_pc got %h expected %h", pcA, 32'h204); end
    flush = 1'b0; valid = 1'b0;
    step();
  endtask

  task automatic test_decode_coverage();
    logic [31:0] vecs [10];
    logic        expc [10];
    vecs = '{32'h03E0_0008, 32'h03E0_0009, 32'h1000_0004, 32'h1400_0000, 32'h1800_0000,
             32'h1C00_0000, 32'h0400_0000, 32'h0800_0000, 32'h0C00_0000, 32'h2008_0005};
    expc = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    inst = 32'h1000_0004; valid = 1'b0;
    step();
    vectors++; if (frzA !== 1'b0) begin miscompares++; $display("[TB] FAIL dc_invalid_frz got %b expected 0", frzA); end
    vectors++; if (instA !== 32'h0) begin miscompares++; $display("[TB] FAIL dc_invalid_inst got %h expected %h", instA, 32'h0); end
    for (int i = 0; i < 10; i++) begin
      inst = vecs[i]; valid = 1'b1;
      step();
      vectors++; if (ctiA !== expc[i]) begin miscompares++; $display("[TB] FAIL dc_cti%0d got %b expected %b", i, ctiA, expc[i]); end
      vectors++; if (frzA !== expc[i]) begin miscompares++; $display("[TB] FAIL dc_frz%0d got %b expected %b", i, frzA, expc[i]); end
      vectors++; if (ctiB !== expc[i]) begin miscompares++; $display("[TB] FAIL dc_ctiB%0d got %b expected %b", i, ctiB, expc[i]); end
      vectors++; if (frzB !== 1'b0) begin miscompares++; $display("[TB] FAIL dc_frzB%0d got %b expected 0", i, frzB); end
      vectors++; if (instB !== vecs[i]) begin miscompares++; $display("[TB] FAIL dc_instB%0d got %h expected %h", i, instB, vecs[i]); end
      inst = 32'h2008_0005;
      step();
      vectors++; if (instB !== 32'h2008_0005) begin miscompares++; $display("[TB] FAIL dc_passB%0d got %h expected %h", i, instB, 32'h2008_0005); end
      vectors++; if (frzA !== expc[i]) begin miscompares++; $display("[TB] FAIL dc_hold%0d got %b expected %b", i, frzA, expc[i]); end
      valid = 1'b0;
      step();
      step();
    end
  endtask

  task automatic test_config();
    inst = 32'h2008_0005; valid = 1'b1;
    pc64 = 64'h0000_0001_0000_0004; inst64 = 64'hDEAD_BEEF_1000_0004;
    step();
    vectors++; if (instC !== 64'hDEAD_BEEF_1000_0004) begin miscompares++; $display("[TB] FAIL cf_instC got %h expected %h", instC, 64'hDEAD_BEEF_1000_0004); end
    vectors++; if (ctiC !== 1'b1) begin miscompares++; $display("[TB] FAIL cf_ctiC got %b expected 1", ctiC); end
    vectors++; if (frzC !== 1'b1) begin miscompares++; $display("[TB] FAIL cf_frzC got %b expected 1", frzC); end
    vectors++; if (frzD !== 1'b1) begin miscompares++; $display("[TB] FAIL cf_frzD got %b expected 1", frzD); end
    vectors++; if (pcD !== 64'h0000_0001_0000_0004) begin miscompares++; $display("[TB] FAIL cf_pcD got %h expected %h", pcD, 64'h0000_0001_0000_0004); end
    pc64 = 64'h0000_0001_0000_0008; inst64 = 64'h0000_0000_2008_0005;
    for (int k = 1; k <= 15; k++) begin
      step();
      vectors++; if (frzC !== 1'b0) begin miscompares++; $display("[TB] FAIL cf_frzC%0d got %b expected 0", k, frzC); end
      vectors++; if (frzD !== (k < 15)) begin miscompares++; $display("[TB] FAIL cf_frzD%0d got %b expected %b", k, frzD, (k < 15)); end
      vectors++; if (validD !== 1'b0) begin miscompares++; $display("[TB] FAIL cf_validD%0d got %b expected 0", k, validD); end
      vectors++; if (validC !== (k >= 2)) begin miscompares++; $display("[TB] FAIL cf_validC%0d got %b expected %b", k, validC, (k >= 2)); end
    end
    step();
    vectors++; if (validD !== 1'b1) begin miscompares++; $display("[TB] FAIL cf_nextD_valid got %b expected 1", validD); end
    vectors++; if (instD !== 64'h0000_0000_2008_0005) begin miscompares++; $display("[TB] FAIL cf_nextD_inst got %h expected %h", instD, 64'h2008_0005); end
    vectors++; if (pcD !== 64'h0000_0001_0000_0008) begin miscompares++; $display("[TB] FAIL cf_nextD_pc got %h expected %h", pcD, 64'h0000_0001_0000_0008); end
    valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      vectors++; if (frzD !== 1'b0) begin miscompares++; $display("[TB] FAIL cf_nowrap%0d got %b expected 0", k, frzD); end
    end
  endtask

  initial begin
    $display("[TB] starting if_id_pipe_reg bench");
    test_reset();
    test_freeze_timing();
    test_stall_in_freeze();
    test_flush_in_freeze();
    test_decode_coverage();
    test_config();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
